// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, mux select codes and match helpers for the hazard scheduler
package hazard_pkg;
  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] FWD_D_RF = 2'd0, FWD_D_E_PC8 = 2'd1, FWD_D_M_RES = 2'd2, FWD_D_W_RES = 2'd3;
  localparam logic [1:0] FWD_E_PIPE = 2'd0, FWD_E_M_RES = 2'd1, FWD_E_W_RES = 2'd2;
  localparam logic FWD_M_PIPE = 1'b0, FWD_M_W_RES = 1'b1;
  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] tnew;
  } dst_t;
  typedef struct packed {
    dst_t       dst;
    logic [4:0] rs;
    logic [4:0] rt;
  } stage_t;
  function automatic dst_t adv(input dst_t s);
    return '{wa: s.wa, tnew: s.tnew == 2'd0 ? 2'd0 : s.tnew - 2'd1};
  endfunction
  // wa==0 is both "no destination" and $0, so it can never match
  function automatic logic hit(input dst_t s, input logic [4:0] r);
    return s.wa != 5'd0 && s.wa == r;
  endfunction
  function automatic logic ready(input dst_t s, input logic [4:0] r);
    return hit(s, r) && s.tnew == 2'd0;
  endfunction
  function automatic logic late(input dst_t s, input logic [4:0] r, input logic [1:0] tuse);
    return hit(s, r) && tuse != TUSE_NONE && s.tnew > tuse;
  endfunction
endpackage

// File: rtl/hazard_sched_md_busy_counter.sv
// md_busy_counter: mult/div busy countdown
//   clk, reset (async, active-low); load: mult/div in E; is_div: selects div length; busy: count != 0
module md_busy_counter #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic is_div,
  output logic busy
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (load) cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
    else if (busy) cnt <= cnt - CNT_W'(1);
  assign busy = cnt != '0;
endmodule

// File: rtl/hazard_sched.sv
// hazard_sched: stall, forwarding selects and mult/div sequencing for a 5-stage MIPS pipeline
//   clk, reset (async, active-low)
//   d_*: decoded D-stage instruction (sources, tuse, destination, tnew, mult/div and HI/LO flags)
//   stall: freeze PC and F/D, bubble into E
//   fwd_d_rs/rt, fwd_e_rs/rt, fwd_m_rt: operand mux selects; md_start, md_busy: mult/div status
module hazard_sched
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_wa,
  input  logic [1:0] d_tnew,
  input  logic       d_is_md,
  input  logic       d_is_div,
  input  logic       d_use_hilo,
  output logic       stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic       fwd_m_rt,
  output logic       md_start,
  output logic       md_busy
);
  // Past E only the fields still consulted are kept: M needs rt for store data, W only its destination
  stage_t     e;
  dst_t       m, w;
  logic [4:0] m_rt;
  logic       e_md, e_div, take;
  assign take = d_valid && !stall;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      e     <= '0;
      m     <= '0;
      m_rt  <= '0;
      w     <= '0;
      e_md  <= 1'b0;
      e_div <= 1'b0;
    end else begin
      w     <= adv(m);
      m     <= adv(e.dst);
      m_rt  <= e.rt;
      e     <= take ? '{dst: '{wa: d_wa, tnew: d_tnew}, rs: d_rs, rt: d_rt} : '0;
      e_md  <= take && d_is_md;
      e_div <= take && d_is_div;
    end
  assign md_start = e_md;
  md_busy_counter #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) u_md (
    .clk(clk), .reset(reset), .load(e_md), .is_div(e_div), .busy(md_busy)
  );
  assign stall = d_valid && (late(e.dst, d_rs, d_tuse_rs) || late(m, d_rs, d_tuse_rs) ||
                             late(e.dst, d_rt, d_tuse_rt) || late(m, d_rt, d_tuse_rt) ||
                             (d_use_hilo && (md_busy || md_start)));
  assign fwd_d_rs = ready(e.dst, d_rs) ? FWD_D_E_PC8 : ready(m, d_rs) ? FWD_D_M_RES :
                    ready(w, d_rs) ? FWD_D_W_RES : FWD_D_RF;
  assign fwd_d_rt = ready(e.dst, d_rt) ? FWD_D_E_PC8 : ready(m, d_rt) ? FWD_D_M_RES :
                    ready(w, d_rt) ? FWD_D_W_RES : FWD_D_RF;
  assign fwd_e_rs = ready(m, e.rs) ? FWD_E_M_RES : ready(w, e.rs) ? FWD_E_W_RES : FWD_E_PIPE;
  assign fwd_e_rt = ready(m, e.rt) ? FWD_E_M_RES : ready(w, e.rt) ? FWD_E_W_RES : FWD_E_PIPE;
  assign fwd_m_rt = hit(w, m_rt) ? FWD_M_W_RES : FWD_M_PIPE;
endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: directed checks of stall, forwarding and mult/div sequencing
module tb_hazard_sched;
  logic       clk = 1'b0, reset;
  logic       d_valid, d_is_md, d_is_div, d_use_hilo;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       stall, fwd_m_rt, md_start, md_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  int         n_checks = 0, n_fail = 0;
  hazard_sched dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wa(d_wa), .d_tnew(d_tnew),
    .d_is_md(d_is_md), .d_is_div(d_is_div), .d_use_hilo(d_use_hilo),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs),
    .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt), .md_start(md_start), .md_busy(md_busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_fwd(input string tag, input int drs, input int drt, input int ers, input int ert, input int mrt);
    check({tag, "_fwd_d_rs"}, 32'(fwd_d_rs), drs);
    check({tag, "_fwd_d_rt"}, 32'(fwd_d_rt), drt);
    check({tag, "_fwd_e_rs"}, 32'(fwd_e_rs), ers);
    check({tag, "_fwd_e_rt"}, 32'(fwd_e_rt), ert);
    check({tag, "_fwd_m_rt"}, 32'(fwd_m_rt), mrt);
  endtask
  task automatic set_d(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] urs,
                       input logic [1:0] urt, input logic [4:0] wa, input logic [1:0] tn,
                       input logic md, input logic dv, input logic hl);
    d_valid = v; d_rs = rs; d_rt = rt; d_tuse_rs = urs; d_tuse_rt = urt;
    d_wa = wa; d_tnew = tn; d_is_md = md; d_is_div = dv; d_use_hilo = hl;
  endtask
  task automatic idle();
    set_d(0, 0, 0, 3, 3, 0, 0, 0, 0, 0);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic md_run(input string tag, input logic dv, input int exp_cycles);
    int n;
    logic held;
    tick(); set_d(1, 4, 5, 1, 1, 0, 0, 1, dv, 1); #2;
    check({tag, "_in_d_stall"}, 32'(stall), 0);
    tick(); set_d(1, 0, 0, 3, 3, 12, 1, 0, 0, 1); #2;
    check({tag, "_start"}, 32'(md_start), 1);
    check({tag, "_start_stall"}, 32'(stall), 1);
    check({tag, "_start_busy"}, 32'(md_busy), 0);
    tick(); #2;
    check({tag, "_start_pulse"}, 32'(md_start), 0);
    n = 0;
    held = 1'b1;
    while (md_busy && n < 40) begin
      if (!stall) held = 1'b0;
      n++;
      tick(); #2;
    end
    check({tag, "_busy_cycles"}, n, exp_cycles);
    check({tag, "_stall_held"}, 32'(held), 1);
    check({tag, "_release"}, 32'(stall), 0);
    tick(); idle();
  endtask
  initial begin
    reset = 1'b0;
    idle();
    #12;
    check("rst_stall", 32'(stall), 0);
    check("rst_busy", 32'(md_busy), 0);
    check("rst_start", 32'(md_start), 0);
    chk_fwd("rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    // lw $8 then beq $8: two stalls, then W forward
    tick(); set_d(1, 29, 0, 1, 3, 8, 2, 0, 0, 0); #2;
    check("lw_nostall", 32'(stall), 0);
    tick(); set_d(1, 8, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    check("beq_stall1", 32'(stall), 1);
    tick(); #2;
    check("beq_stall2", 32'(stall), 1);
    tick(); #2;
    check("beq_go", 32'(stall), 0);
    check("beq_fwd_w", 32'(fwd_d_rs), 3);
    // addu $9 then consumer in E
    tick(); set_d(1, 1, 2, 1, 1, 9, 1, 0, 0, 0); #2;
    check("addu9_nostall", 32'(stall), 0);
    tick(); set_d(1, 9, 3, 1, 1, 10, 1, 0, 0, 0); #2;
    check("use9_nostall", 32'(stall), 0);
    check("use9_d_not_ready", 32'(fwd_d_rs), 0);
    tick(); set_d(1, 4, 9, 1, 1, 0, 0, 0, 0, 0); #2;
    check("e_rs_fwd_m", 32'(fwd_e_rs), 1);
    check("e_rt_pipe", 32'(fwd_e_rt), 0);
    check("d_rt_fwd_m", 32'(fwd_d_rt), 2);
    tick(); idle(); #2;
    check("e_rt_fwd_w", 32'(fwd_e_rt), 2);
    check("e_rs_pipe2", 32'(fwd_e_rs), 0);
    // jal then jr $31
    tick(); set_d(1, 0, 0, 3, 3, 31, 0, 0, 0, 0); #2;
    check("jal_nostall", 32'(stall), 0);
    tick(); set_d(1, 31, 0, 0, 3, 0, 0, 0, 0, 0); #2;
    check("jr_nostall", 32'(stall), 0);
    check("jr_fwd_pc8", 32'(fwd_d_rs), 1);
    tick(); set_d(1, 31, 0, 1, 3, 11, 1, 0, 0, 0); #2;
    check("ra_fwd_m", 32'(fwd_d_rs), 2);
    for (int i = 0; i < 3; i++) begin
      tick(); idle();
    end
    md_run("div", 1'b1, 10);
    md_run("mult", 1'b0, 5);
    // writes to $0 never forward or stall
    for (int i = 0; i < 3; i++) begin
      tick(); set_d(1, 0, 0, 1, 3, 0, 2, 0, 0, 0); #2;
      check("zero_fill_stall", 32'(stall), 0);
    end
    tick(); set_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    check("zero_stall", 32'(stall), 0);
    chk_fwd("zero", 0, 0, 0, 0, 0);
    // lw $5 then sw $5: store data from W
    tick(); set_d(1, 29, 0, 1, 3, 5, 2, 0, 0, 0); #2;
    tick(); set_d(1, 29, 5, 1, 2, 0, 0, 0, 0, 0); #2;
    check("sw_nostall", 32'(stall), 0);
    tick(); idle(); #2;
    check("sw_e_not_ready", 32'(fwd_e_rt), 0);
    tick(); #2;
    check("sw_fwd_m_rt", 32'(fwd_m_rt), 1);
    // reset asserted mid-div with a stall pending
    tick(); set_d(1, 1, 2, 1, 1, 7, 1, 0, 0, 0); #2;
    tick(); set_d(1, 7, 0, 1, 3, 0, 0, 1, 1, 1); #2;
    check("rdiv_nostall", 32'(stall), 0);
    tick(); set_d(1, 7, 0, 0, 3, 12, 1, 0, 0, 1); #2;
    check("rdiv_stall", 32'(stall), 1);
    check("rdiv_start", 32'(md_start), 1);
    check("rdiv_fwd_d_m", 32'(fwd_d_rs), 2);
    check("rdiv_fwd_e_m", 32'(fwd_e_rs), 1);
    tick(); #2;
    check("rdiv_busy", 32'(md_busy), 1);
    check("rdiv_stall2", 32'(stall), 1);
    check("rdiv_fwd_d_w", 32'(fwd_d_rs), 3);
    reset = 1'b0;
    #1;
    check("arst_stall", 32'(stall), 0);
    check("arst_busy", 32'(md_busy), 0);
    check("arst_start", 32'(md_start), 0);
    chk_fwd("arst", 0, 0, 0, 0, 0);
    tick(); #2;
    check("arst_hold_busy", 32'(md_busy), 0);
    reset = 1'b1;
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
